mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between an instruction
// fetch read port and a load/store port. Data normally wins; a streak counter
// bounds how long fetch can be starved. Grants are combinational, responses
// come one cycle later from a registered owner tag.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int MAX_STREAK = 4,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  enable,
  // instruction fetch read port
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // shared RAM, 1-cycle read latency
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  addr_err
);

  // Counter must be able to hold MAX_STREAK; keep at least one bit.
  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  // Word-index limit compared against addr[DATA_WIDTH-1:2].
  localparam logic [DATA_WIDTH-3:0] DEPTH_LIM = (DATA_WIDTH-2)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DRD,
    OWN_DWR,
    OWN_ERR_IF,
    OWN_ERR_D
  } owner_t;

  owner_t        owner_reg, owner_next;
  logic [SW-1:0] streak_reg, streak_next;
  logic          if_oor, d_oor, fetch_first;

  // Byte-offset bits never select a word; folded here only to mark them consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  assign if_oor = (if_addr[DATA_WIDTH-1:2] >= DEPTH_LIM);
  assign d_oor  = (d_addr[DATA_WIDTH-1:2]  >= DEPTH_LIM);

  // Owner tag and streak counter; reset drops any access in flight.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      owner_reg  <= OWN_NONE;
      streak_reg <= '0;
    end else begin
      owner_reg  <= owner_next;
      streak_reg <= streak_next;
    end
  end

  // Arbitration, RAM command and next owner/streak for this cycle's grant.
  always_comb begin
    fetch_first = if_req && (streak_reg == STREAK_MAX);
    d_gnt       = enable && d_req && !fetch_first;
    if_gnt      = enable && if_req && !d_gnt;
    mem_en      = 1'b0;
    mem_we      = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = '0;
    owner_next  = OWN_NONE;
    streak_next = streak_reg;

    if (d_gnt) begin
      if (d_oor) begin
        owner_next = OWN_ERR_D;
      end else begin
        mem_en   = 1'b1;
        mem_addr = d_addr[AW+1:2];
        if (d_we) begin
          owner_next = OWN_DWR;
          mem_we     = d_be;
          mem_wdata  = d_wdata;
        end else begin
          owner_next = OWN_DRD;
        end
      end
    end else if (if_gnt) begin
      if (if_oor) begin
        owner_next = OWN_ERR_IF;
      end else begin
        owner_next = OWN_IF;
        mem_en     = 1'b1;
        mem_addr   = if_addr[AW+1:2];
      end
    end

    // Streak only counts data wins that made fetch wait.
    if (!if_req || if_gnt) begin
      streak_next = '0;
    end else if (d_gnt && (streak_reg != STREAK_MAX)) begin
      streak_next = streak_reg + SW'(1);
    end
  end

  // Responses owed for the access granted in the previous cycle.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    addr_err  = 1'b0;
    case (owner_reg)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      OWN_DRD: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      OWN_DWR: begin
        d_rvalid = 1'b1;
      end
      OWN_ERR_IF: begin
        if_rvalid = 1'b1;
        addr_err  = 1'b1;
      end
      OWN_ERR_D: begin
        d_rvalid = 1'b1;
        addr_err = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-access vectors from a table, then
// hand-written sequences for starvation, enable drop and mid-access reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .MAX_STREAK(4)) dut (
    .clk(clk), .rstN(rstN), .enable(enable),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  typedef struct {
    logic en; logic ifr; logic [31:0] ifa;
    logic dr; logic dwe; logic [3:0] dbe; logic [31:0] da; logic [31:0] dwd;
    logic [31:0] rd;
    logic igt; logic dgt; logic men; logic [3:0] mwe; logic [9:0] maddr; logic [31:0] mwd;
    logic irv; logic [31:0] ird; logic drv; logic [31:0] drd; logic aerr;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    enable = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic chk_grant(input string tag, input bit exp_if);
    chk({tag, " if_gnt"}, 32'(if_gnt), 32'(exp_if));
    chk({tag, " d_gnt"}, 32'(d_gnt), 32'(!exp_if));
  endtask

  initial begin
    //            en ifr ifa            dr dwe dbe   da             dwd            rd
    //            igt dgt men mwe   maddr    mwd            irv ird            drv drd            aerr
    vec[0]  = '{1, 1, 32'h10,       0, 0, 4'h0, 32'h0,       32'h0,        32'hDEADBEEF,
                1, 0, 1, 4'h0, 10'd4,   32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        0};
    vec[1]  = '{1, 0, 32'h0,        1, 1, 4'h3, 32'h8,       32'h1234,     32'hAAAA5555,
                0, 1, 1, 4'h3, 10'd2,   32'h1234,     0, 32'h0,        1, 32'h0,        0};
    vec[2]  = '{1, 0, 32'h0,        1, 0, 4'hF, 32'h20,      32'hFFFF,     32'hCAFEF00D,
                0, 1, 1, 4'h0, 10'd8,   32'h0,        0, 32'h0,        1, 32'hCAFEF00D, 0};
    vec[3]  = '{1, 0, 32'h0,        1, 0, 4'h0, 32'h1000,    32'h0,        32'h11111111,
                0, 1, 0, 4'h0, 10'd0,   32'h0,        0, 32'h0,        1, 32'h0,        1};
    vec[4]  = '{1, 1, 32'h10000010, 0, 0, 4'h0, 32'h0,       32'h0,        32'h22222222,
                1, 0, 0, 4'h0, 10'd0,   32'h0,        1, 32'h0,        0, 32'h0,        1};
    vec[5]  = '{1, 1, 32'h44,       1, 0, 4'h0, 32'h40,      32'h0,        32'h5A5A0001,
                0, 1, 1, 4'h0, 10'h10,  32'h0,        0, 32'h0,        1, 32'h5A5A0001, 0};
    vec[6]  = '{0, 1, 32'h44,       1, 1, 4'hF, 32'h40,      32'h99,       32'h33333333,
                0, 0, 0, 4'h0, 10'd0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
    vec[7]  = '{1, 1, 32'hFFC,      0, 0, 4'h0, 32'h0,       32'h0,        32'h0BADF00D,
                1, 0, 1, 4'h0, 10'h3FF, 32'h0,        1, 32'h0BADF00D, 0, 32'h0,        0};
    vec[8]  = '{1, 0, 32'h0,        1, 1, 4'hF, 32'h1004,    32'h77,       32'h44444444,
                0, 1, 0, 4'h0, 10'd0,   32'h0,        0, 32'h0,        1, 32'h0,        1};
    vec[9]  = '{1, 0, 32'h0,        0, 0, 4'h0, 32'h0,       32'h0,        32'h55555555,
                0, 0, 0, 4'h0, 10'd0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
    vec[10] = '{1, 0, 32'h0,        1, 1, 4'hC, 32'h0B,      32'hABCD0000, 32'h66666666,
                0, 1, 1, 4'hC, 10'd2,   32'hABCD0000, 0, 32'h0,        1, 32'h0,        0};

    // Reset state
    idle_inputs();
    mem_rdata = 32'hFFFFFFFF;
    rstN = 1'b0;
    #3;
    chk("reset if_rvalid", 32'(if_rvalid), 32'h0);
    chk("reset d_rvalid", 32'(d_rvalid), 32'h0);
    chk("reset addr_err", 32'(addr_err), 32'h0);
    chk("reset d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Table: one access cycle, then one idle response cycle
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      enable = vec[i].en; if_req = vec[i].ifr; if_addr = vec[i].ifa;
      d_req = vec[i].dr; d_we = vec[i].dwe; d_be = vec[i].dbe;
      d_addr = vec[i].da; d_wdata = vec[i].dwd; mem_rdata = 32'h0;
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", i), 32'(if_gnt), 32'(vec[i].igt));
      chk($sformatf("v%0d d_gnt", i), 32'(d_gnt), 32'(vec[i].dgt));
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vec[i].men));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vec[i].mwe));
      chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vec[i].maddr));
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vec[i].mwd);
      @(posedge clk); #1;
      idle_inputs();
      mem_rdata = vec[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(vec[i].irv));
      chk($sformatf("v%0d if_rdata", i), if_rdata, vec[i].ird);
      chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(vec[i].drv));
      chk($sformatf("v%0d d_rdata", i), d_rdata, vec[i].drd);
      chk($sformatf("v%0d addr_err", i), 32'(addr_err), 32'(vec[i].aerr));
      $display("vector %0d done", i);
    end

    // Both ports held for 6 cycles: D,D,D,D,IF,D, with back-to-back responses
    begin
      bit exp_if [6] = '{0, 0, 0, 0, 1, 0};
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      for (int c = 0; c < 6; c++) begin
        mem_rdata = 32'hA0000000 | 32'(c);
        @(negedge clk);
        chk_grant($sformatf("streak c%0d", c), exp_if[c]);
        if (c > 0) begin
          chk($sformatf("streak c%0d if_rvalid", c), 32'(if_rvalid), 32'(exp_if[c-1]));
          chk($sformatf("streak c%0d d_rvalid", c), 32'(d_rvalid), 32'(!exp_if[c-1]));
          chk($sformatf("streak c%0d rdata", c), exp_if[c-1] ? if_rdata : d_rdata,
              32'hA0000000 | 32'(c));
        end
        $display("streak cycle %0d grant %s", c, if_gnt ? "IF" : (d_gnt ? "D" : "-"));
        @(posedge clk); #1;
      end
      idle_inputs();
      mem_rdata = 32'hA0000006;
      @(negedge clk);
      chk("streak last d_rvalid", 32'(d_rvalid), 32'h1);
      chk("streak last d_rdata", d_rdata, 32'hA0000006);
    end

    // enable dropped the cycle after a fetch grant
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h30;
    @(negedge clk);
    chk("en_drop grant", 32'(if_gnt), 32'h1);
    @(posedge clk); #1;
    enable = 1'b0; d_req = 1'b1; d_addr = 32'h20; mem_rdata = 32'h600DCAFE;
    @(negedge clk);
    chk("en_drop if_gnt", 32'(if_gnt), 32'h0);
    chk("en_drop d_gnt", 32'(d_gnt), 32'h0);
    chk("en_drop mem_en", 32'(mem_en), 32'h0);
    chk("en_drop if_rvalid", 32'(if_rvalid), 32'h1);
    chk("en_drop if_rdata", if_rdata, 32'h600DCAFE);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("en_drop no resp if", 32'(if_rvalid), 32'h0);
    chk("en_drop no resp d", 32'(d_rvalid), 32'h0);
    $display("enable drop sequence done");

    // Reset after a data read grant with a built-up streak
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_grant($sformatf("pre_rst c%0d", c), 1'b0);
      @(posedge clk); #1;
    end
    mem_rdata = 32'hBAD0BAD0;
    rstN = 1'b0;
    #1;
    chk("rst d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    chk("rst if_rvalid", 32'(if_rvalid), 32'h0);
    chk("rst addr_err", 32'(addr_err), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chk_grant("post_rst c0", 1'b0);
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      chk_grant($sformatf("post_rst c%0d", c), c == 4);
    end
    $display("reset sequence done");
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
